// File: rtl/mdr_mem_ctrl.sv
// MAR/MDR holding stage with a read/write handshake to a 32-bit word memory.
// Drives MDR onto the datapath bus and flags a memory that never acknowledges.
module mdr_mem_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [31:0]       BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       BusMuxIn_MDR,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t            state;
    logic [ADDR_W-1:0] mar;
    logic [31:0]       mdr;
    logic [7:0]        wait_cnt;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= IDLE;
            mar      <= '0;
            mdr      <= '0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MARin)
                        mar <= BusMuxOut[ADDR_W-1:0];
                    // A pending read owns MDR, so the bus load is dropped.
                    if (MDRin && !Read)
                        mdr <= BusMuxOut;
                    if (Read) begin
                        state    <= RD_WAIT;
                        wait_cnt <= '0;
                        mem_err  <= 1'b0;
                    end else if (Write) begin
                        state    <= WR_WAIT;
                        wait_cnt <= '0;
                        mem_err  <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (mem_ready) begin
                        mdr   <= mem_rdata;
                        state <= DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state   <= DONE;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                WR_WAIT: begin
                    if (mem_ready) begin
                        state <= DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state   <= DONE;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode the state register only; no input reaches them.
    assign mem_rd       = (state == RD_WAIT);
    assign mem_wr       = (state == WR_WAIT);
    assign mem_done     = (state == DONE);
    assign mem_busy     = (state != IDLE);
    assign mem_addr     = mar;
    assign mem_wdata    = mdr;
    assign BusMuxIn_MDR = mdr;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Directed bench for mdr_mem_ctrl: expected MDR/err per access are queued at
// request time and compared when mem_done is observed.
module tb_mdr_mem_ctrl;

    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 15;

    logic              clock = 1'b0;
    logic              clear;
    logic [31:0]       BusMuxOut;
    logic              MARin, MDRin, Read, Write;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_rd, mem_wr;
    logic [31:0]       BusMuxIn_MDR;
    logic              mem_busy, mem_done, mem_err;

    typedef struct {
        logic [31:0] mdr;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rd_cycles, wr_cycles;

    mdr_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut),
        .MARin(MARin), .MDRin(MDRin), .Read(Read), .Write(Write),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .BusMuxIn_MDR(BusMuxIn_MDR),
        .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs the wait phase of an access already sampled at edge 0. mem_ready is
    // raised on wait cycle ready_at (0 = never). Counts rd/wr cycles, then pops
    // the scoreboard entry at the DONE cycle.
    task automatic run_access(input string tag, input int ready_at, input logic [31:0] rdata,
                              output int rd_n, output int wr_n);
        int   n = 0;
        int   wcnt = 0;
        exp_t e;
        rd_n = 0;
        wr_n = 0;
        while (!mem_done && n < 40) begin
            if (mem_rd) rd_n++;
            if (mem_wr) wr_n++;
            if (mem_rd || mem_wr) begin
                wcnt++;
                mem_ready = (ready_at != 0) && (wcnt == ready_at);
                mem_rdata = rdata;
            end
            tick();
            MARin = 1'b0;
            n++;
        end
        mem_ready = 1'b0;
        if (!mem_done) begin
            check({tag, "_done_timeout"}, 64'(mem_done), 64'd1);
        end else if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_mdr"}, 64'(BusMuxIn_MDR), 64'(e.mdr));
            check({tag, "_err"}, 64'(mem_err), 64'(e.err));
        end
    endtask

    initial begin
        clear = 1'b1; BusMuxOut = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
        mem_rdata = '0; mem_ready = 0;
        tick(); tick();
        clear = 1'b0;
        check("reset_outs",
              64'({mem_addr, mem_wdata, BusMuxIn_MDR, mem_rd, mem_wr, mem_busy, mem_done, mem_err}),
              64'd0);

        // MAR load from bus
        MARin = 1; BusMuxOut = 32'h0000_01A5;
        tick();
        MARin = 0;
        check("mar_load", 64'(mem_addr), 64'h1A5);

        // MDR load then zero-wait write
        MDRin = 1; BusMuxOut = 32'hDEAD_BEEF;
        tick();
        MDRin = 0;
        check("mdr_load", 64'(mem_wdata), 64'hDEAD_BEEF);
        Write = 1;
        sb.push_back('{mdr: 32'hDEAD_BEEF, err: 1'b0});
        tick();
        Write = 0;
        check("wr_cycle1", 64'({mem_wr, mem_rd, mem_busy}), 64'b101);
        run_access("write0", 1, 32'h0, rd_cycles, wr_cycles);
        check("write0_wr_cycles", 64'(wr_cycles), 64'd1);
        tick();
        check("write0_idle", 64'({mem_busy, mem_done}), 64'd0);

        // Read with 3 wait states, ready on 4th RD_WAIT cycle
        MARin = 1; BusMuxOut = 32'h0000_0010;
        tick();
        MARin = 0;
        check("mar_010", 64'(mem_addr), 64'h010);
        Read = 1;
        sb.push_back('{mdr: 32'h1234_5678, err: 1'b0});
        tick();
        Read = 0;
        run_access("read3", 4, 32'h1234_5678, rd_cycles, wr_cycles);
        check("read3_rd_cycles", 64'(rd_cycles), 64'd4);
        tick();

        // Timeout: memory never answers, MDR keeps its old value
        Read = 1;
        sb.push_back('{mdr: 32'h1234_5678, err: 1'b1});
        tick();
        Read = 0;
        run_access("timeout", 0, 32'hBAD0_BAD0, rd_cycles, wr_cycles);
        check("timeout_rd_cycles", 64'(rd_cycles), 64'(TIMEOUT));
        tick();
        check("err_sticky_idle", 64'(mem_err), 64'd1);
        Write = 1;
        sb.push_back('{mdr: 32'h1234_5678, err: 1'b0});
        tick();
        Write = 0;
        check("err_cleared_on_accept", 64'(mem_err), 64'd0);
        run_access("write1", 2, 32'h0, rd_cycles, wr_cycles);
        check("write1_wr_cycles", 64'(wr_cycles), 64'd2);
        tick();

        // Read+Write+MDRin together: read only, no bus load; MARin ignored mid-access
        Read = 1; Write = 1; MDRin = 1; BusMuxOut = 32'hCAFE_F00D;
        sb.push_back('{mdr: 32'hA5A5_0001, err: 1'b0});
        tick();
        Read = 0; Write = 0; MDRin = 0;
        check("conflict_rd_only", 64'({mem_rd, mem_wr}), 64'b10);
        check("conflict_no_bus_load", 64'(BusMuxIn_MDR), 64'h1234_5678);
        MARin = 1; BusMuxOut = 32'h0000_0055;
        run_access("conflict", 2, 32'hA5A5_0001, rd_cycles, wr_cycles);
        check("conflict_wr_cycles", 64'(wr_cycles), 64'd0);
        check("mar_stable_in_access", 64'(mem_addr), 64'h010);
        tick();

        // clear during RD_WAIT cycle 2 abandons the access
        Read = 1;
        tick();
        Read = 0;
        tick();
        check("rd_wait_c2", 64'(mem_rd), 64'd1);
        clear = 1;
        tick();
        clear = 0;
        check("clear_mid_read",
              64'({mem_rd, mem_wr, mem_busy, mem_done, BusMuxIn_MDR}), 64'd0);
        tick();
        check("clear_no_done", 64'({mem_done, mem_busy}), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
